// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller for uart_brg: times a 0x55 sync character on Rxd and
// loads the derived fixed-point prescale, holding the BRG off while measuring.
module uart_autobaud_ctrl #(
  parameter int unsigned PRE_W          = 16,
  parameter int unsigned FRAC_W         = 4,
  parameter int unsigned RESET_PRESCALE = 868
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Rxd,
  output logic [PRE_W-1:0] Prescale,
  output logic             BrgEn,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  localparam int unsigned ACC_W  = PRE_W + 2;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned SHIFT  = 6 - FRAC_W;
  localparam int unsigned RND_SH = (SHIFT == 0) ? 0 : SHIFT - 1;
  localparam logic [SUM_W-1:0] RND     = (SHIFT == 0) ? '0 : (SUM_W'(1) << RND_SH);
  localparam logic [SUM_W-1:0] MIN_NEW = SUM_W'(2) << FRAC_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_WAIT_START,
    S_MEASURE,
    S_APPLY
  } state_t;

  state_t             r_state;
  logic               r_rx_s1;
  logic               r_rx_s2;
  logic               r_rx_prev;
  logic [PRE_W-1:0]   r_cnt;
  logic [PRE_W-1:0]   r_i1;
  logic [1:0]         r_idx;
  logic [ACC_W-1:0]   r_acc;
  logic               r_bad;

  logic               w_fall;
  logic [PRE_W-1:0]   w_cnt_inc;
  logic               w_cnt_ovf;
  logic [PRE_W-1:0]   w_ref;
  logic [PRE_W-1:0]   w_diff;
  logic               w_mis;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [SUM_W-1:0]   w_sum;
  logic [SUM_W-1:0]   w_new_full;
  logic               w_low;
  logic               w_big;
  logic               w_reject;

  assign w_fall    = r_rx_prev & ~r_rx_s2;

  // w_cnt_inc is the spacing in cycles between the previous falling edge and this one
  assign w_cnt_inc = r_cnt + PRE_W'(1);
  assign w_cnt_ovf = &w_cnt_inc;

  // Every interval must lie within 25% of the first one
  assign w_ref     = (r_idx == 2'd0) ? w_cnt_inc : r_i1;
  assign w_diff    = (w_cnt_inc >= w_ref) ? (w_cnt_inc - w_ref) : (w_ref - w_cnt_inc);
  assign w_mis     = w_diff > (w_ref >> 2);

  // T8 spans eight bit times; rounding shift leaves FRAC_W fraction bits of the 8x period
  assign w_acc_nxt  = r_acc + ACC_W'(w_cnt_inc);
  assign w_sum      = SUM_W'(w_acc_nxt) + RND;
  assign w_new_full = w_sum >> SHIFT;
  assign w_low      = w_new_full < MIN_NEW;
  assign w_big      = (w_new_full >> PRE_W) != '0;
  assign w_reject   = r_bad | w_mis | w_low | w_big;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= S_IDLE;
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_cnt     <= '0;
      r_i1      <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_bad     <= 1'b0;
      Prescale  <= PRE_W'(RESET_PRESCALE);
      BrgEn     <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
    end else begin
      r_rx_s1   <= Rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      Done      <= 1'b0;
      Err       <= 1'b0;

      case (r_state)
        S_IDLE, S_APPLY: begin
          r_state <= S_IDLE;
          if (Start) begin
            r_state <= S_WAIT_IDLE;
            BrgEn   <= 1'b0;
            Busy    <= 1'b1;
          end
        end

        S_WAIT_IDLE: begin
          if (r_rx_s2) begin
            r_state <= S_WAIT_START;
          end
        end

        S_WAIT_START: begin
          if (w_fall) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_bad   <= 1'b0;
            r_state <= S_MEASURE;
          end
        end

        S_MEASURE: begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_ovf) begin
            r_state <= S_APPLY;
            BrgEn   <= 1'b1;
            Busy    <= 1'b0;
            Err     <= 1'b1;
          end else if (w_fall) begin
            r_cnt <= '0;
            r_acc <= w_acc_nxt;
            r_idx <= r_idx + 2'd1;
            r_bad <= r_bad | w_mis;
            if (r_idx == 2'd0) begin
              r_i1 <= w_cnt_inc;
            end
            if (r_idx == 2'd3) begin
              r_state <= S_APPLY;
              BrgEn   <= 1'b1;
              Busy    <= 1'b0;
              if (w_reject) begin
                Err <= 1'b1;
              end else begin
                Done     <= 1'b1;
                Prescale <= w_new_full[PRE_W-1:0];
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed bench for uart_autobaud_ctrl: a 16-bit instance for the baud cases and a
// 12-bit instance so the counter timeout is reached in a short run.
module tb_uart_autobaud_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (PRE_W = 16)
  logic        rst, start, rxd;
  logic [15:0] prescale;
  logic        brg_en, busy, done, err;

  // Small instance (PRE_W = 12): timeout at 4095 cycles
  logic        rst_s, start_s, rxd_s;
  logic [11:0] prescale_s;
  logic        brg_en_s, busy_s, done_s, err_s;

  uart_autobaud_ctrl #(.PRE_W(16), .FRAC_W(4), .RESET_PRESCALE(868)) u_dut (
    .Clk(clk), .Rst(rst), .Start(start), .Rxd(rxd),
    .Prescale(prescale), .BrgEn(brg_en), .Busy(busy), .Done(done), .Err(err)
  );

  uart_autobaud_ctrl #(.PRE_W(12), .FRAC_W(4), .RESET_PRESCALE(868)) u_dut_s (
    .Clk(clk), .Rst(rst_s), .Start(start_s), .Rxd(rxd_s),
    .Prescale(prescale_s), .BrgEn(brg_en_s), .Busy(busy_s), .Done(done_s), .Err(err_s)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse bookkeeping, sampled between active edges
  int unsigned n_done = 0, n_err = 0, t_done = 0, t_err = 0, n_both = 0, n_busy_pulse = 0;
  int unsigned n_done_s = 0, n_err_s = 0, t_err_s = 0;
  always @(negedge clk) begin
    if (done) begin n_done++; t_done = cyc; end
    if (err) begin n_err++; t_err = cyc; end
    if (done && err) n_both++;
    if ((done || err) && busy) n_busy_pulse++;
    if (done_s) n_done_s++;
    if (err_s) begin n_err_s++; t_err_s = cyc; end
    if (done_s && err_s) n_both++;
  end

  int unsigned n_pass = 0, n_fail = 0, n_total = 0;
  int unsigned t_fall [16];
  int unsigned d0, e0, tf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start_s = 1'b1; else start = 1'b1;
    @(negedge clk);
    if (sel) start_s = 1'b0; else start = 1'b0;
  endtask

  // Drive seq[0] first, each level held bt cycles; records the cycle of every falling edge
  task automatic drive_line(input bit sel, input logic [31:0] seq, input int nbits, input int bt);
    int   nf;
    logic prev;
    nf   = 0;
    prev = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (sel) rxd_s = seq[i]; else rxd = seq[i];
      if (prev && !seq[i]) begin
        t_fall[nf] = cyc;
        nf++;
      end
      prev = seq[i];
      repeat (bt - 1) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rxd = 1'b1;
    rst_s = 1'b1; start_s = 1'b0; rxd_s = 1'b1;

    // Reset held 10 cycles, Start raised during the last cycles: reset wins
    repeat (8) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy_during", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0; rst_s = 1'b0;
    @(negedge clk);
    chk("rst_prescale", 32'(prescale), 32'd868);
    chk("rst_brgen", 32'(brg_en), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // 9600 baud: 5208-cycle bits, T8 = 41664, new = 41666>>2 = 10416
    pulse_start(1'b0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_brgen", 32'(brg_en), 32'd0);
    repeat (5) @(negedge clk);
    d0 = n_done; e0 = n_err;
    drive_line(1'b0, 32'({1'b1, 8'h55, 1'b0}), 10, 5208);
    repeat (4) @(negedge clk);
    chk("b9600_prescale", 32'(prescale), 32'd10416);
    chk("b9600_done_cnt", n_done - d0, 32'd1);
    chk("b9600_err_cnt", n_err - e0, 32'd0);
    chk("b9600_done_lat", t_done - t_fall[4], 32'd3);
    chk("b9600_brgen", 32'(brg_en), 32'd1);
    chk("b9600_busy", 32'(busy), 32'd0);

    // 0x0F then 0x55 back to back: intervals 5B,5B,2B,2B -> mismatch on the 3rd
    pulse_start(1'b0);
    repeat (5) @(negedge clk);
    d0 = n_done; e0 = n_err;
    drive_line(1'b0, 32'({1'b1, 8'h55, 1'b0, 1'b1, 8'h0F, 1'b0}), 20, 434);
    repeat (4) @(negedge clk);
    chk("mis_err_cnt", n_err - e0, 32'd1);
    chk("mis_done_cnt", n_done - d0, 32'd0);
    chk("mis_err_lat", t_err - t_fall[4], 32'd3);
    chk("mis_prescale_kept", 32'(prescale), 32'd10416);
    chk("mis_brgen", 32'(brg_en), 32'd1);

    // 115200 baud: 434-cycle bits, T8 = 3472, new = 3474>>2 = 868
    pulse_start(1'b0);
    repeat (5) @(negedge clk);
    d0 = n_done; e0 = n_err;
    drive_line(1'b0, 32'({1'b1, 8'h55, 1'b0}), 10, 434);
    repeat (4) @(negedge clk);
    chk("b115k_prescale", 32'(prescale), 32'd868);
    chk("b115k_done_cnt", n_done - d0, 32'd1);
    chk("b115k_done_lat", t_done - t_fall[4], 32'd3);

    // Too fast: 10-cycle bits, T8 = 80, new = 20 < 32
    pulse_start(1'b0);
    repeat (5) @(negedge clk);
    d0 = n_done; e0 = n_err;
    drive_line(1'b0, 32'({1'b1, 8'h55, 1'b0}), 10, 10);
    repeat (4) @(negedge clk);
    chk("fast_err_cnt", n_err - e0, 32'd1);
    chk("fast_done_cnt", n_done - d0, 32'd0);
    chk("fast_err_lat", t_err - t_fall[4], 32'd3);
    chk("fast_prescale_kept", 32'(prescale), 32'd868);

    // Small instance: 40-cycle bits, T8 = 320, new = 322>>2 = 80
    pulse_start(1'b1);
    repeat (5) @(negedge clk);
    d0 = n_done_s;
    drive_line(1'b1, 32'({1'b1, 8'h55, 1'b0}), 10, 40);
    repeat (4) @(negedge clk);
    chk("s_prescale", 32'(prescale_s), 32'd80);
    chk("s_done_cnt", n_done_s - d0, 32'd1);

    // Timeout: Rxd held low after the start edge, counter saturates at 4095
    pulse_start(1'b1);
    repeat (5) @(negedge clk);
    e0 = n_err_s;
    @(negedge clk);
    rxd_s = 1'b0;
    tf = cyc;
    repeat (4200) @(negedge clk);
    chk("to_err_cnt", n_err_s - e0, 32'd1);
    chk("to_err_lat", t_err_s - tf, 32'd4098);
    chk("to_prescale_kept", 32'(prescale_s), 32'd80);
    chk("to_brgen", 32'(brg_en_s), 32'd1);
    chk("to_busy", 32'(busy_s), 32'd0);
    rxd_s = 1'b1;

    // Reset mid-measurement: everything back to reset values one cycle later
    repeat (5) @(negedge clk);
    pulse_start(1'b1);
    repeat (5) @(negedge clk);
    rxd_s = 1'b0;
    repeat (100) @(negedge clk);
    chk("rm_busy_before", 32'(busy_s), 32'd1);
    chk("rm_brgen_before", 32'(brg_en_s), 32'd0);
    rst_s = 1'b1;
    @(negedge clk);
    chk("rm_prescale", 32'(prescale_s), 32'd868);
    chk("rm_brgen", 32'(brg_en_s), 32'd1);
    chk("rm_busy", 32'(busy_s), 32'd0);
    chk("rm_done_err", 32'({done_s, err_s}), 32'd0);
    rst_s = 1'b0;
    rxd_s = 1'b1;
    repeat (5) @(negedge clk);

    chk("never_done_and_err", n_both, 32'd0);
    chk("pulse_busy_low", n_busy_pulse, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
